downscale_frame_loader: RTL and testbench
=========================================

Name: downscale_frame_loader

Overview:
Upstream feeder for the sequential bilinear downscaler. Accepts a raster-order 8-bit pixel stream over a valid/ready handshake and assembles one full SRC_H x SRC_W source frame in a register array. When the frame is complete, it pulses start to the downscaler. It then holds the frame stable until the downscaler reports done, and re-arms for the next frame.

Parameters:
SRC_H, 32, source frame height in pixels (rows)
SRC_W, 32, source frame width in pixels (columns)
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  upstream pixel valid
s_data  in  8  upstream pixel value, raster order (row-major, column fastest)
s_last  in  1  upstream marks the final pixel of a frame
s_ready  out  1  loader can accept a pixel this cycle
image_in  out  8 x [0:SRC_H-1][0:SRC_W-1]  assembled frame; connects directly to the downscaler image_in
ds_start  out  1  one-cycle start pulse to the downscaler
ds_done  in  1  downscaler done
busy  out  1  frame handed off; waiting for ds_done
frame_err  out  1  sticky framing error
frame_count  out  CNT_W  number of frames completed by the downscaler

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, and state when rst is sampled high:
  - state=LOAD, row=0, col=0.
  - s_ready=0, ds_start=0, busy=0, frame_err=0, frame_count=0.
  - image_in is not cleared; its contents are don't-care.
- All outputs are registered.
- s_ready first goes 1 in the cycle after rst is sampled low.
- FSM states: LOAD, START, WAIT.
- LOAD:
  - s_ready=1.
  - Transfer occurs when s_valid && s_ready at a rising edge; then image_in[row][col] <= s_data.
  - col increments. When col==SRC_W-1, col wraps to 0 and row increments.
  - A transfer at row==SRC_H-1, col==SRC_W-1 is the final transfer. Then row and col return to 0, s_ready=0 from the next cycle, and the FSM goes to START.
  - No transfer occurs on cycles with s_valid=0. No pixel is dropped or duplicated under any valid/ready pattern.
- START:
  - ds_start=1 for exactly this one cycle; s_ready=0.
  - ds_done is ignored in this cycle.
  - Next state is WAIT.
- WAIT:
  - busy=1, s_ready=0; s_valid is ignored.
  - image_in is unchanged for the whole of START and WAIT.
  - When ds_done is sampled 1: frame_count increments (wraps modulo 2^CNT_W), busy=0, FSM goes to LOAD, and s_ready=1 in the next cycle.
  - A ds_done that stays high for several cycles counts once.
- Throughput: with s_valid held high, a frame loads in SRC_H*SRC_W cycles.
  - ds_start rises in the cycle after the final transfer.
- frame_err is set (sticky until rst) in either case:
  - s_last=1 on a transfer that is not the final transfer;
  - s_last=0 on the final transfer.
- Frame completion is always governed by the pixel count, never by s_last.
- Simultaneous rst and any handshake or ds_done: rst wins; no write, no count.
- Reset mid-load: a partially loaded frame is abandoned, and the next frame fills from [0][0].

Test Plan:
1. Reset, then stream 32x32 pixels of (i*4+j*2)&0xFF with s_valid=1 and s_last on the final pixel only.
   -> 1024 transfers in 1024 consecutive cycles; ds_start high for 1 cycle immediately after; image_in[0][0]=0, image_in[1][1]=6, image_in[31][31]=186; frame_err=0.
2. Same frame with s_valid randomly deasserted about 40% of cycles.
   -> Identical image_in contents; exactly 1024 writes; one ds_start pulse.
3. After ds_start, hold s_valid=1 and assert ds_done 200 cycles later for 3 cycles.
   -> busy=1 and s_ready=0 throughout the wait; image_in unchanged; frame_count=1; s_ready=1 on the cycle after ds_done is first sampled.
4. Assert s_last on pixel index 10, and leave s_last low on pixel 1023.
   -> frame_err=1 from the cycle after pixel 10; ds_start still fires after pixel 1023; frame_err stays 1 through a subsequent clean frame.
5. Assert rst for 1 cycle after 500 transfers, then send a full new frame of constant 0x55.
   -> Outputs return to reset values; the new frame fills from [0][0]; all image_in entries are 0x55; frame_count=0 until ds_done.
6. Two back-to-back frames with different content, each acknowledged by ds_done.
   -> Two ds_start pulses; the second frame fully overwrites the first; frame_count=2.

Source files
------------

// File: rtl/downscale_frame_loader.sv
// downscale_frame_loader
//   Collects one SRC_H x SRC_W frame of 8-bit pixels, streamed in raster order
//   over a valid/ready handshake, into a register array. When the frame is
//   complete it pulses ds_start. It then holds the frame stable until ds_done
//   and re-arms for the next frame.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   s_valid/s_ready       pixel handshake; s_data is the pixel, s_last marks the
//                         upstream's idea of the final pixel
//   image_in              assembled frame, image_in[row][col]
//   ds_start/ds_done      start pulse to / completion from the downscaler
//   busy                  frame handed off, waiting for ds_done
//   frame_err             sticky: s_last disagreed with the pixel count
//   frame_count           frames acknowledged by the downscaler (wraps)
module downscale_frame_loader #(
    parameter int SRC_H = 32,
    parameter int SRC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    input  logic [7:0]                             s_data,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [0:SRC_H-1][0:SRC_W-1][7:0]       image_in,
    output logic                                   ds_start,
    input  logic                                   ds_done,
    output logic                                   busy,
    output logic                                   frame_err,
    output logic [CNT_W-1:0]                       frame_count
);

    localparam int RW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int CW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(SRC_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SRC_W - 1);

    typedef enum logic [1:0] {LOAD, START, WAIT} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              s_ready_q, s_ready_d;
    logic              ds_start_q, ds_start_d;
    logic              busy_q, busy_d;
    logic              xfer, final_xfer;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        xfer       = (state_q == LOAD) && s_valid && s_ready_q;
        final_xfer = xfer && (row_q == ROW_LAST) && (col_q == COL_LAST);

        case (state_q)
            LOAD: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = START;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    // Completion follows the pixel count; s_last is only audited.
                    if (s_last != final_xfer) err_d = 1'b1;
                end
            end
            START: state_d = WAIT;  // ds_done deliberately ignored here
            WAIT: begin
                if (ds_done) begin
                    state_d = LOAD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are registered from the next state so they line up with it.
        s_ready_d  = (state_d == LOAD);
        ds_start_d = (state_d == START);
        busy_d     = (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            ds_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            s_ready_q  <= s_ready_d;
            ds_start_q <= ds_start_d;
            busy_q     <= busy_d;
        end
    end

    // Frame storage has no reset; writes are only blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && xfer) image_in[row_q][col_q] <= s_data;
    end

    assign s_ready     = s_ready_q;
    assign ds_start    = ds_start_q;
    assign busy        = busy_q;
    assign frame_err   = err_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_downscale_frame_loader.sv
module tb_downscale_frame_loader;

    localparam int H = 32;
    localparam int W = 32;
    localparam int N = H * W;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        s_valid = 1'b0;
    logic [7:0]                  s_data = '0;
    logic                        s_last = 1'b0;
    logic                        s_ready;
    logic [0:H-1][0:W-1][7:0]    image_in;
    logic                        ds_start;
    logic                        ds_done = 1'b0;
    logic                        busy;
    logic                        frame_err;
    logic [15:0]                 frame_count;

    downscale_frame_loader #(.SRC_H(H), .SRC_W(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .image_in(image_in), .ds_start(ds_start), .ds_done(ds_done),
        .busy(busy), .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Independent handshake / pulse monitor
    int xfers = 0;
    int starts = 0;
    always @(posedge clk) begin
        if (!rst && s_valid && s_ready) xfers++;
        if (ds_start) starts++;
    end

    // Reference model: the frame is the ordered list of accepted pixels.
    logic [7:0] model_img [N];
    logic [7:0] rnd_frame [N];
    logic       exp_err = 1'b0;
    int         exp_fc = 0;
    int         err_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixval(input int mode, input int idx);
        case (mode)
            0:       return 8'(((idx / W) * 4 + (idx % W) * 2) & 8'hFF);
            1:       return 8'h55;
            default: return rnd_frame[idx];
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) rnd_frame[i] = 8'($urandom);
    endtask

    task automatic img_check(input string tag);
        int bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (image_in[r][c] !== model_img[r * W + c]) bad++;
        check(tag, bad, 0);
    endtask

    // Offers up to npix pixels; returns the number of cycles taken.
    task automatic send_frame(input int mode, input int pct, input int last_idx,
                              input int npix, output int cycles);
        int   idx = 0;
        logic acc;
        cycles = 0;
        while (idx < npix && cycles < 20000) begin
            @(negedge clk);
            if (frame_err !== exp_err) err_bad++;
            s_valid = ($urandom_range(0, 99) < pct);
            s_data  = pixval(mode, idx);
            s_last  = (idx == last_idx);
            acc     = s_valid && s_ready;
            @(posedge clk);
            if (acc) begin
                model_img[idx] = s_data;
                if ((idx == last_idx) != (idx == N - 1)) exp_err = 1'b1;
                idx++;
            end
            cycles++;
        end
        if (idx < npix) check("send_timeout", idx, npix);
    endtask

    // Full frame ending at the negedge where ds_start must already be high.
    task automatic full_frame(input string tag, input int mode, input int pct,
                              input int last_idx, output int cycles);
        int x0 = xfers;
        int s0 = starts;
        err_bad = 0;
        send_frame(mode, pct, last_idx, N, cycles);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check({tag, "_start_pulse"}, ds_start, 1'b1);
        check({tag, "_ready_low"}, s_ready, 1'b0);
        check({tag, "_xfers"}, xfers - x0, N);
        check({tag, "_err_track"}, err_bad, 0);
        @(negedge clk);
        check({tag, "_start_once"}, starts - s0, 1);
        img_check({tag, "_img"});
    endtask

    // Waits dly cycles (optionally pushing s_valid), then ds_done for hold cycles.
    task automatic ack(input string tag, input int dly, input int hold, input logic push);
        int bad = 0;
        int x0 = xfers;
        s_valid = push;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && s_ready === 1'b0 && ds_start === 1'b0)) bad++;
        end
        check({tag, "_wait_state"}, bad, 0);
        check({tag, "_no_xfer"}, xfers - x0, 0);
        img_check({tag, "_img_held"});
        check({tag, "_fc_before"}, frame_count, 16'(exp_fc));
        s_valid = 1'b0;
        ds_done = 1'b1;
        @(negedge clk);
        exp_fc = (exp_fc + 1) % 65536;
        check({tag, "_ready_back"}, s_ready, 1'b1);
        check({tag, "_busy_clr"}, busy, 1'b0);
        for (int i = 1; i < hold; i++) @(negedge clk);
        ds_done = 1'b0;
        @(negedge clk);
        check({tag, "_fc"}, frame_count, 16'(exp_fc));
    endtask

    initial begin
        int cyc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", s_ready, 1'b0);
        check("rst_start", ds_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_fc", frame_count, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", s_ready, 1'b1);

        // 1: gradient frame at full rate
        full_frame("t1", 0, 100, N - 1, cyc);
        check("t1_cycles", cyc, N);
        check("t1_px00", image_in[0][0], 8'd0);
        check("t1_px11", image_in[1][1], 8'd6);
        check("t1_px3131", image_in[31][31], 8'd186);
        check("t1_err", frame_err, 1'b0);

        // 3: long wait with s_valid pushing, ds_done held 3 cycles
        ack("t3", 200, 3, 1'b1);

        // 2: same frame with ~40% bubbles
        full_frame("t2", 0, 60, N - 1, cyc);
        ack("t2", 5, 1, 1'b0);

        // 6: two back-to-back random frames
        fill_random();
        full_frame("t6a", 2, 80, N - 1, cyc);
        ack("t6a", 3, 1, 1'b0);
        fill_random();
        full_frame("t6b", 2, 70, N - 1, cyc);
        ack("t6b", 3, 2, 1'b0);
        check("t6_fc", frame_count, 16'd4);

        // 4: misplaced s_last, then a clean frame keeps the sticky error
        fill_random();
        full_frame("t4", 2, 90, 10, cyc);
        check("t4_err", frame_err, 1'b1);
        ack("t4", 4, 1, 1'b0);
        full_frame("t4c", 0, 100, N - 1, cyc);
        check("t4_err_sticky", frame_err, 1'b1);
        ack("t4c", 2, 1, 1'b0);

        // 5: reset after 500 transfers, with handshake and ds_done colliding
        fill_random();
        err_bad = 0;
        send_frame(2, 100, N - 1, 500, cyc);
        @(negedge clk);
        rst     = 1'b1;
        ds_done = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", s_ready, 1'b0);
        check("t5_rst_start", ds_start, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_err", frame_err, 1'b0);
        check("t5_rst_fc", frame_count, 16'd0);
        rst     = 1'b0;
        ds_done = 1'b0;
        s_valid = 1'b0;
        exp_err = 1'b0;
        exp_fc  = 0;
        @(negedge clk);
        full_frame("t5", 1, 75, N - 1, cyc);
        check("t5_px00", image_in[0][0], 8'h55);
        check("t5_fc_pre", frame_count, 16'd0);
        check("t5_err", frame_err, 1'b0);
        ack("t5", 10, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout got=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
